// File: rtl/rx_bit_timer_if.sv
// Serial receive bundle: raw line into the bit timer, strobes and assembled data out of it.
// The master side is the bit timer itself; the slave side is the line driver / data consumer.
interface rx_bit_timer_if #(
    parameter int DATA_BITS = 8
);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    logic                 serial_in;
    logic                 shift_strobe;
    logic [IDX_W-1:0]     bit_index;
    logic [DATA_BITS-1:0] rx_data;
    logic                 packet_done;
    logic                 framing_error;
    logic                 busy;

    modport master (
        input  serial_in,
        output shift_strobe, bit_index, rx_data, packet_done, framing_error, busy
    );

    modport slave (
        output serial_in,
        input  shift_strobe, bit_index, rx_data, packet_done, framing_error, busy
    );
endinterface

// File: rtl/rx_bit_timer.sv
// Receive-side bit timing: qualifies the start bit at mid-bit, strobes each data bit at
// bit centre while assembling the word LSB first, and samples the stop bit for framing.
module rx_bit_timer #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic           clk,
    input  logic           rst,
    rx_bit_timer_if.master bus
);
    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [TMR_W-1:0] HALF_BIT = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] FULL_BIT = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 sync_1;
    logic                 sync_2;
    logic                 prev;
    logic                 start_edge;
    logic [TMR_W-1:0]     timer;
    logic [IDX_W-1:0]     bit_index_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic [DATA_BITS-1:0] rx_data_shifted;
    logic                 framing_error_q;
    logic                 shift_strobe;
    logic                 packet_done;
    logic                 frame_start;

    // All three flops come out of reset high so an idle line never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            prev   <= 1'b1;
        end else begin
            sync_1 <= bus.serial_in;
            sync_2 <= sync_1;
            prev   <= sync_2;
        end
    end

    assign start_edge = prev & ~sync_2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_strobe = 1'b0;
        packet_done  = 1'b0;
        frame_start  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d     = START;
                    frame_start = 1'b1;
                end
            end
            START: begin
                if (timer == HALF_BIT) begin
                    state_d = sync_2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer == FULL_BIT) begin
                    shift_strobe = 1'b1;
                    if (bit_index_q == LAST_IDX) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (timer == FULL_BIT) begin
                    packet_done = 1'b1;
                    // A start edge landing on the stop sample chains straight into the next frame.
                    if (start_edge) begin
                        state_d     = START;
                        frame_start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The timer restarts on every state change and on each data strobe, so it counts within a bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if ((state_d != state_q) || shift_strobe) begin
            timer <= '0;
        end else begin
            timer <= timer + TMR_W'(1);
        end
    end

    always_comb begin
        rx_data_shifted                = rx_data_q >> 1;
        rx_data_shifted[DATA_BITS-1]   = sync_2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_index_q     <= '0;
            rx_data_q       <= '0;
            framing_error_q <= 1'b0;
        end else if (frame_start) begin
            bit_index_q     <= '0;
            rx_data_q       <= '0;
            framing_error_q <= 1'b0;
        end else begin
            if (shift_strobe) begin
                rx_data_q   <= rx_data_shifted;
                bit_index_q <= bit_index_q + IDX_W'(1);
            end
            if (packet_done) begin
                framing_error_q <= ~sync_2;
            end
        end
    end

    assign bus.shift_strobe  = shift_strobe;
    assign bus.packet_done   = packet_done;
    assign bus.bit_index     = bit_index_q;
    assign bus.rx_data       = rx_data_q;
    assign bus.framing_error = framing_error_q;
    assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_rx_bit_timer.sv
// Directed bench for rx_bit_timer at 10 clocks per bit, 8 data bits. Cycle c in the
// recorded queues is the cycle after edge N+c, where edge N samples the first start-bit low.
module tb_rx_bit_timer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rx_bit_timer_if #(.DATA_BITS(8)) bus ();

    rx_bit_timer #(
        .CLKS_PER_BIT(10),
        .DATA_BITS   (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic       line_q[$];
    int         strobe_q[$];
    int         done_q[$];
    logic [7:0] done_data_q[$];
    logic [3:0] done_idx_q[$];
    logic       busy_q[$];
    logic       fe_q[$];
    int         overlap;

    // Line image: start bit for 10 cycles, data LSB first, stop bit, then idle high.
    task automatic build_frame(input logic [7:0] data, input logic stop_val,
                               input int stop_cycles, input int tail);
        line_q.delete();
        repeat (10) line_q.push_back(1'b0);
        for (int b = 0; b < 8; b++) repeat (10) line_q.push_back(data[b]);
        repeat (stop_cycles) line_q.push_back(stop_val);
        repeat (tail) line_q.push_back(1'b1);
    endtask

    // Drives line_q one value per cycle and records what the DUT shows each cycle.
    task automatic run_line();
        strobe_q.delete(); done_q.delete(); done_data_q.delete(); done_idx_q.delete();
        busy_q.delete(); fe_q.delete();
        overlap = 0;
        for (int k = 0; k < line_q.size(); k++) begin
            @(negedge clk);
            if (k > 0) begin
                busy_q.push_back(bus.busy);
                fe_q.push_back(bus.framing_error);
                if (bus.shift_strobe) strobe_q.push_back(k - 1);
                if (bus.packet_done) begin
                    done_q.push_back(k - 1);
                    done_data_q.push_back(bus.rx_data);
                    done_idx_q.push_back(bus.bit_index);
                end
                if (bus.shift_strobe && bus.packet_done) overlap++;
            end
            bus.serial_in = line_q[k];
        end
    endtask

    task automatic test_reset();
        int pulses;
        rst = 1'b1;
        bus.serial_in = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (bus.shift_strobe !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_strobe: got %b expected 0", bus.shift_strobe); end
        vectors++; if (bus.packet_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", bus.packet_done); end
        vectors++; if (bus.framing_error !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ferr: got %b expected 0", bus.framing_error); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        vectors++; if (bus.bit_index !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_bit_index: got %0d expected 0", bus.bit_index); end
        vectors++; if (bus.rx_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_rx_data: got %h expected 00", bus.rx_data); end
        pulses = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.shift_strobe !== 1'b0 || bus.packet_done !== 1'b0 || bus.busy !== 1'b0) pulses++;
        end
        vectors++; if (pulses !== 0) begin miscompares++; $display("[TB] FAIL idle_quiet: got %0d active cycles expected 0", pulses); end
    endtask

    task automatic test_frame_a5();
        build_frame(8'hA5, 1'b1, 10, 12);
        run_line();
        vectors++; if (strobe_q.size() !== 8) begin miscompares++; $display("[TB] FAIL a5_strobe_count: got %0d expected 8", strobe_q.size()); end
        for (int i = 0; i < 8; i++) begin
            int got;
            got = (i < strobe_q.size()) ? strobe_q[i] : -1;
            vectors++; if (got !== 16 + 10 * i) begin miscompares++; $display("[TB] FAIL a5_strobe_%0d: got cycle %0d expected %0d", i, got, 16 + 10 * i); end
        end
        vectors++; if (done_q.size() !== 1 || done_q[0] !== 96) begin miscompares++; $display("[TB] FAIL a5_done_cycle: got %0d pulses first at %0d expected 1 at 96", done_q.size(), done_q.size() ? done_q[0] : -1); end
        vectors++; if (done_data_q.size() !== 1 || done_data_q[0] !== 8'hA5) begin miscompares++; $display("[TB] FAIL a5_rx_data: got %h expected a5", done_data_q.size() ? done_data_q[0] : 8'hxx); end
        vectors++; if (done_idx_q.size() !== 1 || done_idx_q[0] !== 4'd8) begin miscompares++; $display("[TB] FAIL a5_bit_index: got %0d expected 8", done_idx_q.size() ? done_idx_q[0] : 4'hx); end
        vectors++; if (overlap !== 0) begin miscompares++; $display("[TB] FAIL a5_overlap: got %0d expected 0", overlap); end
        vectors++; if ({busy_q[1], busy_q[2], busy_q[96], busy_q[97]} !== 4'b0110) begin miscompares++; $display("[TB] FAIL a5_busy_window: got %b%b%b%b expected 0110", busy_q[1], busy_q[2], busy_q[96], busy_q[97]); end
        vectors++; if (bus.framing_error !== 1'b0) begin miscompares++; $display("[TB] FAIL a5_ferr: got %b expected 0", bus.framing_error); end
        vectors++; if (bus.rx_data !== 8'hA5 || bus.bit_index !== 4'd8) begin miscompares++; $display("[TB] FAIL a5_hold: got %h/%0d expected a5/8", bus.rx_data, bus.bit_index); end
    endtask

    task automatic test_false_start();
        line_q.delete();
        repeat (3) line_q.push_back(1'b0);
        repeat (40) line_q.push_back(1'b1);
        run_line();
        vectors++; if ({busy_q[1], busy_q[2], busy_q[6], busy_q[7]} !== 4'b0110) begin miscompares++; $display("[TB] FAIL false_busy_window: got %b%b%b%b expected 0110", busy_q[1], busy_q[2], busy_q[6], busy_q[7]); end
        vectors++; if (strobe_q.size() !== 0 || done_q.size() !== 0) begin miscompares++; $display("[TB] FAIL false_pulses: got %0d strobes %0d dones expected 0 0", strobe_q.size(), done_q.size()); end
        vectors++; if (bus.framing_error !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL false_end_state: got ferr %b busy %b expected 0 0", bus.framing_error, bus.busy); end
    endtask

    task automatic test_framing_error();
        build_frame(8'h3C, 1'b0, 10, 30);
        run_line();
        vectors++; if (done_q.size() !== 1 || done_q[0] !== 96) begin miscompares++; $display("[TB] FAIL fe_done_cycle: got %0d pulses first at %0d expected 1 at 96", done_q.size(), done_q.size() ? done_q[0] : -1); end
        vectors++; if (done_data_q.size() !== 1 || done_data_q[0] !== 8'h3C) begin miscompares++; $display("[TB] FAIL fe_rx_data: got %h expected 3c", done_data_q.size() ? done_data_q[0] : 8'hxx); end
        vectors++; if ({fe_q[96], fe_q[97], fe_q[125]} !== 3'b011) begin miscompares++; $display("[TB] FAIL fe_flag: got %b%b%b expected 011", fe_q[96], fe_q[97], fe_q[125]); end
        vectors++; if (strobe_q.size() !== 8) begin miscompares++; $display("[TB] FAIL fe_strobe_count: got %0d expected 8", strobe_q.size()); end
        build_frame(8'h81, 1'b1, 10, 12);
        run_line();
        vectors++; if ({fe_q[1], fe_q[2]} !== 2'b10) begin miscompares++; $display("[TB] FAIL fe_clear_on_start: got %b%b expected 10", fe_q[1], fe_q[2]); end
        vectors++; if (done_data_q.size() !== 1 || done_data_q[0] !== 8'h81) begin miscompares++; $display("[TB] FAIL fe_next_rx_data: got %h expected 81", done_data_q.size() ? done_data_q[0] : 8'hxx); end
        vectors++; if (bus.framing_error !== 1'b0) begin miscompares++; $display("[TB] FAIL fe_next_ferr: got %b expected 0", bus.framing_error); end
    endtask

    task automatic test_back_to_back();
        // First frame's stop bit is cut to 5 cycles so the next start edge hits its packet_done cycle.
        build_frame(8'h01, 1'b1, 5, 0);
        run_line();
        vectors++; if (strobe_q.size() !== 8) begin miscompares++; $display("[TB] FAIL b2b_first_strobes: got %0d expected 8", strobe_q.size()); end
        build_frame(8'hFF, 1'b1, 10, 12);
        run_line();
        vectors++; if (done_q.size() !== 2) begin miscompares++; $display("[TB] FAIL b2b_done_count: got %0d expected 2", done_q.size()); end
        vectors++; if (done_q.size() !== 2 || done_q[0] !== 1 || done_q[1] !== 96) begin miscompares++; $display("[TB] FAIL b2b_done_cycles: got %0d,%0d expected 1,96", done_q.size() > 0 ? done_q[0] : -1, done_q.size() > 1 ? done_q[1] : -1); end
        vectors++; if (done_data_q.size() !== 2 || done_data_q[0] !== 8'h01 || done_data_q[1] !== 8'hFF) begin miscompares++; $display("[TB] FAIL b2b_rx_data: got %h,%h expected 01,ff", done_data_q.size() > 0 ? done_data_q[0] : 8'hxx, done_data_q.size() > 1 ? done_data_q[1] : 8'hxx); end
        vectors++; if ({busy_q[1], busy_q[2], busy_q[3]} !== 3'b111) begin miscompares++; $display("[TB] FAIL b2b_no_idle: got %b%b%b expected 111", busy_q[1], busy_q[2], busy_q[3]); end
        vectors++; if ({fe_q[2], bus.framing_error} !== 2'b00) begin miscompares++; $display("[TB] FAIL b2b_ferr: got %b%b expected 00", fe_q[2], bus.framing_error); end
        vectors++; if (strobe_q.size() !== 8 || strobe_q[0] !== 16) begin miscompares++; $display("[TB] FAIL b2b_second_strobes: got %0d first at %0d expected 8 first at 16", strobe_q.size(), strobe_q.size() ? strobe_q[0] : -1); end
    endtask

    task automatic test_reset_mid_frame();
        build_frame(8'hC3, 1'b1, 10, 0);
        while (line_q.size() > 50) void'(line_q.pop_back());
        run_line();
        @(negedge clk);
        vectors++; if (strobe_q.size() !== 4) begin miscompares++; $display("[TB] FAIL mid_strobe_count: got %0d expected 4", strobe_q.size()); end
        vectors++; if (bus.rx_data !== 8'h30 || bus.bit_index !== 4'd4 || bus.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_partial: got %h/%0d/%b expected 30/4/1", bus.rx_data, bus.bit_index, bus.busy); end
        rst = 1'b1;
        bus.serial_in = 1'b1;
        #1;
        vectors++; if (bus.rx_data !== 8'h00 || bus.bit_index !== 4'd0 || bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset: got %h/%0d/%b expected 00/0/0", bus.rx_data, bus.bit_index, bus.busy); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        build_frame(8'h5A, 1'b1, 10, 12);
        run_line();
        vectors++; if (done_q.size() !== 1 || done_q[0] !== 96) begin miscompares++; $display("[TB] FAIL post_reset_done: got %0d pulses first at %0d expected 1 at 96", done_q.size(), done_q.size() ? done_q[0] : -1); end
        vectors++; if (done_data_q.size() !== 1 || done_data_q[0] !== 8'h5A) begin miscompares++; $display("[TB] FAIL post_reset_rx_data: got %h expected 5a", done_data_q.size() ? done_data_q[0] : 8'hxx); end
        vectors++; if (strobe_q.size() !== 8) begin miscompares++; $display("[TB] FAIL post_reset_strobes: got %0d expected 8", strobe_q.size()); end
    endtask

    initial begin
        bus.serial_in = 1'b1;
        test_reset();
        test_frame_a5();
        test_false_start();
        test_framing_error();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
